// File: rtl/arb_pkg.sv
// ---------------------------------------------------------------------------
// arb_pkg
// Shared definitions for the source arbiter slice:
//   arb_state_e  : arbiter sequencing states (IDLE / RUN / DRAIN)
//   ARB_DATA_W   : default word width of the number-generator sources
//   SRC_FIB/TMR  : fixed source indices of the fibonacci and timer generators
// ---------------------------------------------------------------------------
package arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_RUN   = 2'd1,
    ARB_DRAIN = 2'd2
  } arb_state_e;

  localparam int ARB_DATA_W = 16;

  localparam int SRC_FIB = 0;
  localparam int SRC_TMR = 1;

endpackage

// File: rtl/src_arbiter_rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick
// Purely combinational round-robin picker. Searches req_valid starting at
// (ptr + 1) mod N_SRC, upward with wrap, and reports the first hit.
//   req_valid  in   N_SRC  per-source request
//   ptr        in   SRC_W  index of the most recently granted source
//   grant      out  N_SRC  one-hot of the chosen source (zero if none)
//   grant_idx  out  SRC_W  index of the chosen source (zero if none)
//   grant_vld  out  1      at least one request present
// ---------------------------------------------------------------------------
module rr_pick
  import arb_pkg::*;
#(
  parameter int unsigned N_SRC = 2,
  parameter int unsigned SRC_W = $clog2(N_SRC)
) (
  input  logic [N_SRC-1:0] req_valid,
  input  logic [SRC_W-1:0] ptr,
  output logic [N_SRC-1:0] grant,
  output logic [SRC_W-1:0] grant_idx,
  output logic             grant_vld
);

  logic [N_SRC-1:0] mask;
  int unsigned      cand;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_vld = 1'b0;
    mask      = '0;
    cand      = 0;
    // Offset k = 1..N_SRC visits ptr+1 first and ptr itself last.
    for (int unsigned k = 1; k <= N_SRC; k++) begin
      cand = (32'(ptr) + k) % N_SRC;
      mask = N_SRC'(1) << cand;
      if (!grant_vld && ((req_valid & mask) != '0)) begin
        grant     = mask;
        grant_idx = cand[SRC_W-1:0];
        grant_vld = 1'b1;
      end
    end
  end

endmodule

// File: rtl/src_arbiter.sv
// ---------------------------------------------------------------------------
// src_arbiter
// Round-robin arbiter / sequencer sharing the single write port of the
// clock-crossing buffer between the number-generator sources. A one-entry
// hold register is the only storage; words are granted one per acceptance
// and written as soon as the buffer is not full. A stop pulse drains the
// hold register and waits for the buffer to empty before pulsing drained.
//
// Optional feature macro: ARB_PARITY_EN adds the registered even-parity
// output wr_parity (XOR of the held word).
//
// Ports:
//   clk, rst_n    clock (rising edge), asynchronous active-low reset
//   start, stop   single-cycle control pulses
//   req_valid     per-source word available
//   req_data      per-source words, source i at [i*DATA_W +: DATA_W]
//   req_ready     one-hot grant
//   buf_full      buffer cannot take a write this cycle
//   buf_empty     buffer fully read out
//   wr_en         write strobe to buffer
//   wr_data       held word
//   wr_src        source index of held word
//   active_src    index of last granted source
//   busy          arbiter not idle
//   wr_parity     (ARB_PARITY_EN only) even parity of held word
//   drained       single-cycle pulse on drain completion
// ---------------------------------------------------------------------------
module src_arbiter
  import arb_pkg::*;
#(
  parameter int N_SRC  = 2,
  parameter int DATA_W = ARB_DATA_W,
  parameter int SRC_W  = $clog2(N_SRC)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    stop,
  input  logic [N_SRC-1:0]        req_valid,
  input  logic [N_SRC*DATA_W-1:0] req_data,
  output logic [N_SRC-1:0]        req_ready,
  input  logic                    buf_full,
  input  logic                    buf_empty,
  output logic                    wr_en,
  output logic [DATA_W-1:0]       wr_data,
  output logic [SRC_W-1:0]        wr_src,
  output logic [SRC_W-1:0]        active_src,
  output logic                    busy,
`ifdef ARB_PARITY_EN
  output logic                    wr_parity,
`endif
  output logic                    drained
);

  arb_state_e        state_q,      state_d;
  logic              hold_vld_q,   hold_vld_d;
  logic [DATA_W-1:0] hold_data_q,  hold_data_d;
  logic [SRC_W-1:0]  hold_src_q,   hold_src_d;
  logic [SRC_W-1:0]  ptr_q,        ptr_d;
  logic [SRC_W-1:0]  active_src_q, active_src_d;
  logic              drained_q,    drained_d;

  logic [N_SRC-1:0]  pick_grant;
  logic [SRC_W-1:0]  pick_idx;
  logic              pick_vld;
  logic              grant_en;
  logic              xfer;
  logic [DATA_W-1:0] pick_data;

  rr_pick #(
    .N_SRC (N_SRC),
    .SRC_W (SRC_W)
  ) u_pick (
    .req_valid (req_valid),
    .ptr       (ptr_q),
    .grant     (pick_grant),
    .grant_idx (pick_idx),
    .grant_vld (pick_vld)
  );

  // A word leaves the hold register whenever the buffer has room.
  assign wr_en = hold_vld_q & ~buf_full;

  // Granting while the hold word is being written keeps 1 word/cycle.
  assign grant_en  = (state_q == ARB_RUN) & (~hold_vld_q | wr_en);
  assign req_ready = grant_en ? pick_grant : '0;
  assign xfer      = grant_en & pick_vld;
  assign pick_data = req_data[pick_idx*DATA_W +: DATA_W];

  always_comb begin
    state_d      = state_q;
    hold_vld_d   = hold_vld_q;
    hold_data_d  = hold_data_q;
    hold_src_d   = hold_src_q;
    ptr_d        = ptr_q;
    active_src_d = active_src_q;
    drained_d    = 1'b0;

    if (xfer) begin
      hold_vld_d   = 1'b1;
      hold_data_d  = pick_data;
      hold_src_d   = pick_idx;
      ptr_d        = pick_idx;
      active_src_d = pick_idx;
    end else if (wr_en) begin
      hold_vld_d = 1'b0;
    end

    // A stop in RUN does not block the same-cycle acceptance above;
    // that word is flushed in DRAIN where grant_en is low.
    unique case (state_q)
      ARB_IDLE:  if (start && !stop) state_d = ARB_RUN;
      ARB_RUN:   if (stop) state_d = ARB_DRAIN;
      ARB_DRAIN: begin
        if (!hold_vld_q && buf_empty) begin
          state_d   = ARB_IDLE;
          drained_d = 1'b1;
        end
      end
      default:   state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ARB_IDLE;
      hold_vld_q   <= 1'b0;
      hold_data_q  <= '0;
      hold_src_q   <= '0;
      ptr_q        <= SRC_W'(N_SRC - 1);
      active_src_q <= '0;
      drained_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      hold_vld_q   <= hold_vld_d;
      hold_data_q  <= hold_data_d;
      hold_src_q   <= hold_src_d;
      ptr_q        <= ptr_d;
      active_src_q <= active_src_d;
      drained_q    <= drained_d;
    end
  end

`ifdef ARB_PARITY_EN
  logic parity_q, parity_d;

  always_comb begin
    parity_d = parity_q;
    if (xfer) parity_d = ^pick_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) parity_q <= 1'b0;
    else        parity_q <= parity_d;
  end

  assign wr_parity = parity_q;
`endif

  assign wr_data    = hold_data_q;
  assign wr_src     = hold_src_q;
  assign active_src = active_src_q;
  assign busy       = (state_q != ARB_IDLE);
  assign drained    = drained_q;

endmodule

// File: tb/tb_src_arbiter.sv
// ---------------------------------------------------------------------------
// tb_src_arbiter
// Self-checking bench for src_arbiter with a transaction-level reference
// model (mode variable, one-slot word queue, last-grant index).
// ---------------------------------------------------------------------------
module tb_src_arbiter;

  localparam int N  = 2;
  localparam int DW = 16;
  localparam int SW = 1;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            start, stop;
  logic [N-1:0]    req_valid;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    req_ready;
  logic            buf_full, buf_empty;
  logic            wr_en;
  logic [DW-1:0]   wr_data;
  logic [SW-1:0]   wr_src, active_src;
  logic            busy, drained;
`ifdef ARB_PARITY_EN
  logic            wr_parity;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  src_arbiter #(.N_SRC(N), .DATA_W(DW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .stop       (stop),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .buf_full   (buf_full),
    .buf_empty  (buf_empty),
    .wr_en      (wr_en),
    .wr_data    (wr_data),
    .wr_src     (wr_src),
    .active_src (active_src),
    .busy       (busy),
`ifdef ARB_PARITY_EN
    .wr_parity  (wr_parity),
`endif
    .drained    (drained)
  );

  // ---------------- reference model ----------------
  // m_mode: 0 idle, 1 running, 2 draining
  int            m_mode;
  logic [DW-1:0] hq_data[$];
  int            hq_src[$];
  int            m_last;
  logic [SW-1:0] m_active;
  logic [DW-1:0] m_out_data;
  logic [SW-1:0] m_out_src;
  logic          m_drained;

  task automatic model_reset();
    m_mode = 0;
    hq_data.delete();
    hq_src.delete();
    m_last     = N - 1;
    m_active   = '0;
    m_out_data = '0;
    m_out_src  = '0;
    m_drained  = 1'b0;
  endtask

  // Called at a negedge with inputs already driven; compares, steps the
  // model across the next posedge and returns at the following negedge.
  task automatic model_cycle();
    logic          exp_we;
    logic [N-1:0]  exp_rdy;
    int            g;
    logic          new_drained;
    #1;
    exp_we = (hq_data.size() != 0) && !buf_full;
    g = -1;
    if (m_mode == 1 && (hq_data.size() == 0 || exp_we)) begin
      for (int k = 1; k <= N; k++) begin
        int i;
        i = (m_last + k) % N;
        if (g < 0 && req_valid[i]) g = i;
      end
    end
    exp_rdy = (g >= 0) ? (N'(1) << g) : '0;

    total++;
    if (wr_en !== exp_we) begin
      bad++; $display("FAIL model_wr_en t=%0t got=%b exp=%b", $time, wr_en, exp_we);
    end
    total++;
    if (req_ready !== exp_rdy) begin
      bad++; $display("FAIL model_req_ready t=%0t got=%b exp=%b", $time, req_ready, exp_rdy);
    end
    total++;
    if (wr_data !== m_out_data) begin
      bad++; $display("FAIL model_wr_data t=%0t got=%h exp=%h", $time, wr_data, m_out_data);
    end
    total++;
    if (wr_src !== m_out_src) begin
      bad++; $display("FAIL model_wr_src t=%0t got=%0d exp=%0d", $time, wr_src, m_out_src);
    end
    total++;
    if (active_src !== m_active) begin
      bad++; $display("FAIL model_active_src t=%0t got=%0d exp=%0d", $time, active_src, m_active);
    end
    total++;
    if (busy !== (m_mode != 0)) begin
      bad++; $display("FAIL model_busy t=%0t got=%b exp=%b", $time, busy, (m_mode != 0));
    end
    total++;
    if (drained !== m_drained) begin
      bad++; $display("FAIL model_drained t=%0t got=%b exp=%b", $time, drained, m_drained);
    end
`ifdef ARB_PARITY_EN
    total++;
    if (wr_parity !== ^m_out_data) begin
      bad++; $display("FAIL model_parity t=%0t got=%b exp=%b", $time, wr_parity, ^m_out_data);
    end
`endif

    @(posedge clk);
    new_drained = 1'b0;
    case (m_mode)
      0: if (start && !stop) m_mode = 1;
      1: if (stop) m_mode = 2;
      2: if (hq_data.size() == 0 && buf_empty) begin m_mode = 0; new_drained = 1'b1; end
      default: m_mode = 0;
    endcase
    if (exp_we) begin
      void'(hq_data.pop_front());
      void'(hq_src.pop_front());
    end
    if (g >= 0) begin
      hq_data.push_back(req_data[g*DW +: DW]);
      hq_src.push_back(g);
      m_last     = g;
      m_active   = SW'(g);
      m_out_data = req_data[g*DW +: DW];
      m_out_src  = SW'(g);
    end
    m_drained = new_drained;
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    start = 1'b0; stop = 1'b0; req_valid = '0; req_data = '0;
    buf_full = 1'b0; buf_empty = 1'b1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    idle_inputs();
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    idle_inputs();
    model_reset();
    #1;
    total++;
    if ({wr_en, req_ready, busy, drained, wr_data, wr_src, active_src} !== '0) begin
      bad++; $display("FAIL reset_outputs got we=%b rdy=%b busy=%b dr=%b data=%h src=%0d act=%0d exp all zero",
                      wr_en, req_ready, busy, drained, wr_data, wr_src, active_src);
    end
    @(negedge clk);
    rst_n = 1'b1;
    model_cycle();
  endtask

  task automatic test_single_src();
    start = 1'b1; model_cycle(); start = 1'b0;
    req_valid = 2'b01; req_data = {16'h0, 16'h0001};
    #1; total++;
    if (req_ready !== 2'b01) begin bad++; $display("FAIL single_grant0 got=%b exp=01", req_ready); end
    model_cycle();
    req_data = {16'h0, 16'h0002};
    #1; total++;
    if (!(wr_en === 1'b1 && wr_data === 16'h0001 && wr_src === 1'b0)) begin
      bad++; $display("FAIL single_word1 got we=%b data=%h src=%0d exp we=1 data=0001 src=0", wr_en, wr_data, wr_src);
    end
    model_cycle();
    req_valid = '0;
    #1; total++;
    if (!(wr_en === 1'b1 && wr_data === 16'h0002 && active_src === 1'b0)) begin
      bad++; $display("FAIL single_word2 got we=%b data=%h act=%0d exp we=1 data=0002 act=0", wr_en, wr_data, active_src);
    end
    model_cycle();
    #1; total++;
    if (wr_en !== 1'b0) begin bad++; $display("FAIL single_idle_we got=%b exp=0", wr_en); end
    model_cycle();
  endtask

  task automatic test_fairness();
    apply_reset();
    start = 1'b1; model_cycle(); start = 1'b0;
    for (int k = 0; k < 6; k++) begin
      logic [N-1:0] exp_rdy;
      exp_rdy = (k % 2 == 0) ? 2'b01 : 2'b10;
      req_valid = 2'b11;
      req_data  = {16'($urandom), 16'($urandom)};
      #1; total++;
      if (req_ready !== exp_rdy) begin
        bad++; $display("FAIL fair_grant k=%0d got=%b exp=%b", k, req_ready, exp_rdy);
      end
      if (k > 0) begin
        total++;
        if (!(wr_en === 1'b1 && wr_src === SW'((k - 1) % 2))) begin
          bad++; $display("FAIL fair_wr_src k=%0d got we=%b src=%0d exp we=1 src=%0d", k, wr_en, wr_src, (k - 1) % 2);
        end
      end
      model_cycle();
    end
    req_valid = '0;
    #1; total++;
    if (!(wr_en === 1'b1 && wr_src === 1'b1)) begin
      bad++; $display("FAIL fair_last_src got we=%b src=%0d exp we=1 src=1", wr_en, wr_src);
    end
    model_cycle();
  endtask

  task automatic test_stall();
    req_valid = 2'b01; req_data = {16'h1111, 16'hABCD};
    model_cycle();
    req_valid = 2'b11; buf_full = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #1; total++;
      if (!(wr_en === 1'b0 && req_ready === 2'b00 && wr_data === 16'hABCD)) begin
        bad++; $display("FAIL stall_hold k=%0d got we=%b rdy=%b data=%h exp we=0 rdy=00 data=abcd", k, wr_en, req_ready, wr_data);
      end
      model_cycle();
    end
    buf_full = 1'b0;
    #1; total++;
    if (!(wr_en === 1'b1 && wr_data === 16'hABCD)) begin
      bad++; $display("FAIL stall_release got we=%b data=%h exp we=1 data=abcd", wr_en, wr_data);
    end
    model_cycle();
  endtask

  task automatic test_drain();
    int writes;
    stop = 1'b1; buf_full = 1'b1; buf_empty = 1'b0; req_valid = 2'b11;
    model_cycle();
    stop = 1'b0; buf_full = 1'b0;
    writes = 0;
    for (int k = 0; k < 8; k++) begin
      #1; total++;
      if (!(req_ready === 2'b00 && busy === 1'b1 && drained === 1'b0)) begin
        bad++; $display("FAIL drain_wait k=%0d got rdy=%b busy=%b dr=%b exp rdy=00 busy=1 dr=0", k, req_ready, busy, drained);
      end
      if (wr_en === 1'b1) writes++;
      model_cycle();
    end
    total++;
    if (writes != 1) begin bad++; $display("FAIL drain_flush_count got=%0d exp=1", writes); end
    buf_empty = 1'b1;
    #1; total++;
    if (!(drained === 1'b0 && busy === 1'b1)) begin
      bad++; $display("FAIL drain_exit_cycle got dr=%b busy=%b exp dr=0 busy=1", drained, busy);
    end
    model_cycle();
    #1; total++;
    if (!(drained === 1'b1 && busy === 1'b0)) begin
      bad++; $display("FAIL drain_pulse got dr=%b busy=%b exp dr=1 busy=0", drained, busy);
    end
    model_cycle();
    #1; total++;
    if (drained !== 1'b0) begin bad++; $display("FAIL drain_pulse_width got=%b exp=0", drained); end
    model_cycle();
    req_valid = '0;
  endtask

  task automatic test_start_stop_same();
    start = 1'b1; stop = 1'b1;
    model_cycle();
    start = 1'b0; stop = 1'b0; req_valid = 2'b11;
    #1; total++;
    if (!(busy === 1'b0 && req_ready === 2'b00)) begin
      bad++; $display("FAIL startstop_idle got busy=%b rdy=%b exp busy=0 rdy=00", busy, req_ready);
    end
    model_cycle();
    req_valid = '0;
  endtask

  task automatic test_reset_midrun();
    start = 1'b1; model_cycle(); start = 1'b0;
    req_valid = 2'b01; req_data = {16'h0, 16'h5555}; buf_full = 1'b1;
    model_cycle();
    req_valid = 2'b11;
    model_cycle();
    rst_n = 1'b0;
    buf_full = 1'b0;
    #1; total++;
    if (!(wr_en === 1'b0 && req_ready === 2'b00 && busy === 1'b0)) begin
      bad++; $display("FAIL midrun_reset got we=%b rdy=%b busy=%b exp we=0 rdy=00 busy=0", wr_en, req_ready, busy);
    end
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1; total++;
      if (!(wr_en === 1'b0 && req_ready === 2'b00)) begin
        bad++; $display("FAIL midrun_after k=%0d got we=%b rdy=%b exp we=0 rdy=00", k, wr_en, req_ready);
      end
      model_cycle();
    end
    req_valid = '0;
  endtask

`ifdef ARB_PARITY_EN
  task automatic test_parity();
    apply_reset();
    start = 1'b1; model_cycle(); start = 1'b0;
    req_valid = 2'b01; req_data = {16'h0, 16'h0007};
    model_cycle();
    req_data = {16'h0, 16'h0003};
    #1; total++;
    if (wr_parity !== 1'b1) begin bad++; $display("FAIL parity_0007 got=%b exp=1", wr_parity); end
    model_cycle();
    req_valid = '0;
    #1; total++;
    if (wr_parity !== 1'b0) begin bad++; $display("FAIL parity_0003 got=%b exp=0", wr_parity); end
    model_cycle();
  endtask
`endif

  task automatic test_random();
    apply_reset();
    for (int k = 0; k < 400; k++) begin
      start     = ($urandom_range(0, 7) == 0);
      stop      = ($urandom_range(0, 15) == 0);
      req_valid = N'($urandom);
      req_data  = {16'($urandom), 16'($urandom)};
      buf_full  = ($urandom_range(0, 3) == 0);
      buf_empty = ($urandom_range(0, 2) != 0);
      model_cycle();
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    rst_n = 1'b0;
    @(negedge clk);
    test_reset();
    test_single_src();
    test_fairness();
    test_stall();
    test_drain();
    test_start_stop_same();
    test_reset_midrun();
`ifdef ARB_PARITY_EN
    test_parity();
`endif
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/src_arbiter.md
# src_arbiter

Round-robin arbiter and sequencer that shares the single write port of the clock-crossing buffer between the number-generator sources (fibonacci, timer, and any later ones). It takes start/stop pulses from the control edge detectors and grants one source per accepted word. It holds each word in a one-entry output register until the buffer can take it. On stop, it drains cleanly and signals completion, replacing the ad-hoc enable FSM at top level.

## Interface
- N_SRC, 2: number of requesting sources (2..8)
- DATA_W, 16: word width
- SRC_W, $clog2(N_SRC): source index width
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  single-cycle pulse: begin arbitration
- stop  in  1  single-cycle pulse: end arbitration and drain
- req_valid  in  N_SRC  per-source word available
- req_data  in  N_SRC*DATA_W  per-source word, source i at bits [i*DATA_W +: DATA_W]
- req_ready  out  N_SRC  one-hot grant; transfer when req_valid[i] & req_ready[i]
- buf_full  in  1  buffer cannot accept a write this cycle
- buf_empty  in  1  buffer fully read out
- wr_en  out  1  write strobe to buffer
- wr_data  out  DATA_W  word to buffer
- wr_src  out  SRC_W  source index of wr_data
- active_src  out  SRC_W  index of last granted source (display mode select)
- busy  out  1  state != IDLE
- drained  out  1  single-cycle pulse on DRAIN→IDLE

## Operation
- States: IDLE, RUN, DRAIN.
  - IDLE: start & ~stop → RUN. Simultaneous start & stop → stay IDLE.
  - RUN: stop → DRAIN.
  - DRAIN: ~hold_vld & buf_empty → IDLE, with drained=1 that cycle (registered pulse, visible next cycle).
- Hold register (hold_vld, hold_data, hold_src) is the only storage.
  - wr_en = hold_vld & ~buf_full (combinational). wr_data/wr_src are driven from the hold register.
- Grant:
  - Only in RUN, and only when ~hold_vld | wr_en, so back-to-back acceptance is possible.
  - Granted index is the first i with req_valid[i], searching from (ptr+1) mod N_SRC upward with wrap.
  - req_ready is one-hot on that index, all-zero otherwise.
- On transfer:
  - hold loads req_data of the granted source; hold_vld=1.
  - ptr and active_src take the granted index.
- A write (wr_en) without a new transfer clears hold_vld.
- stop in RUN does not cancel an acceptance in the same cycle. That word is flushed in DRAIN. No grants in DRAIN.
- Reset values: state IDLE, hold_vld 0, hold_data 0, ptr N_SRC-1 (source 0 has first priority), active_src 0, drained 0. Consequently wr_en, req_ready, busy, wr_data and wr_src are all 0.
- Reset mid-operation discards the held word immediately (asynchronous).

## Timing
- Accept at cycle N → wr_en at N+1 if buf_full is low, else held until the first cycle with buf_full low.
- Sustained throughput is 1 word/cycle while buf_full stays low.
- buf_full rising stalls wr_en the same cycle. req_ready drops the same cycle when hold_vld=1.
- Fairness: with all sources continuously valid, grants rotate strictly 0,1,…,N_SRC-1.
- DRAIN latency = hold flush + buffer read-out. The drained pulse appears one cycle after the exit condition.
- busy falls in the same cycle drained rises.

## Configuration
- ARB_PARITY_EN defined: adds output wr_parity (1 bit) = XOR of hold_data, registered alongside the hold word (even parity, reset 0). It replaces the combinational parity at top level.
- ARB_PARITY_EN undefined: the port and its logic are absent.

## Structure
- Package arb_pkg holds:
  - state encodings ARB_IDLE=2'd0, ARB_RUN=2'd1, ARB_DRAIN=2'd2
  - default DATA_W=16
  - shared source index constants SRC_FIB=0, SRC_TMR=1
- Sub-module rr_pick: purely combinational round-robin picker (inputs req_valid, ptr; outputs one-hot grant and index). It is instantiated once.

## Test plan
- Reset release, start, only src0 presents 0x0001 then 0x0002 → wr_en at accept+1 each; wr_data 0x0001, 0x0002; wr_src 0; active_src 0.
- Both sources valid for 6 cycles, buf_full low → grants 0,1,0,1,0,1; wr_src sequence is identical, delayed one cycle.
- hold occupied, buf_full high for 5 cycles → wr_en 0, req_ready 0, wr_data stable. buf_full low → wr_en 1 that same cycle.
- stop with hold occupied and buf_empty low for 8 cycles → no grants after stop; held word written; drained pulses one cycle after buf_empty rises; busy 0.
- start & stop in same cycle from IDLE → busy stays 0. rst_n low during RUN with hold_vld → wr_en and req_ready 0 immediately, no write after release.
- ARB_PARITY_EN: word 0x0007 → wr_parity 1; word 0x0003 → wr_parity 0.
